ssd1306_spi_tx: RTL



---
 rtl/ssd1306_pkg.sv | 20 ++
 rtl/ssd1306_cmd_fifo.sv | 55 +++++
 rtl/ssd1306_spi_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared types for the SSD1306 SPI transmitter
package ssd1306_pkg;

   localparam logic SSD_DC_CMD  = 1'b0;
   localparam logic SSD_DC_DATA = 1'b1;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } spi_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

endpackage

// File: rtl/ssd1306_cmd_fifo.sv
// rtl/ssd1306_cmd_fifo.sv - synchronous {dc, data} command FIFO
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ssd1306_cmd_fifo
   import ssd1306_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  spi_cmd_t push_data,
   input  logic     pop,
   output spi_cmd_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   spi_cmd_t    mem_q [DEPTH];
   spi_cmd_t    mem_d [DEPTH];

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && !full) begin
         mem_d[wr_q[AW-1:0]] = push_data;
         wr_d                = wr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// rtl/ssd1306_spi_tx.sv - SPI mode-0 byte serialiser for the SSD1306 pins
// SSD_SPI_FIFO_EN selects a FIFO_DEPTH command FIFO; otherwise one holding register.
module ssd1306_spi_tx
   import ssd1306_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_dc,
   output logic       busy,
   output logic       spi_cs_n,
   output logic       spi_sck,
   output logic       spi_sdi,
   output logic       spi_dc
);

   localparam int             CW     = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

   if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("ssd1306_spi_tx: CLK_DIV out of range");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ssd1306_spi_tx: FIFO_DEPTH must be a power of two >= 2");
   end

   spi_cmd_t head;
   logic     push, pop, load, full, empty;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;

`ifdef SSD_SPI_FIFO_EN
   ssd1306_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({in_dc, in_data}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );
`else
   spi_cmd_t hold_q, hold_d;
   logic     hold_vld_q, hold_vld_d;

   // push needs the register empty and pop needs it full, so they never collide
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (pop) hold_vld_d = 1'b0;
      if (push) begin
         hold_d     = {in_dc, in_data};
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign head  = hold_q;
   assign full  = hold_vld_q;
   assign empty = !hold_vld_q;
`endif

   spi_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [6:0]    sr_q, sr_d;
   logic          cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d, dc_q, dc_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      sdi_d   = sdi_q;
      dc_d    = dc_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: load = !empty;
         ST_SETUP: begin
            if (cnt_q == '0) begin
               sck_d   = 1'b1;
               cnt_d   = RELOAD;
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = RELOAD;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  // the falling edge after bit 0 either chains the next byte or closes the frame
                  if (bit_q != 3'd0) begin
                     bit_d = bit_q - 1'b1;
                     sdi_d = sr_q[6];
                     sr_d  = {sr_q[5:0], 1'b0};
                  end else if (!empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               cs_d    = 1'b1;
               cnt_d   = RELOAD;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         sr_d    = head.data[6:0];
         sdi_d   = head.data[7];
         dc_d    = head.dc;
         cs_d    = 1'b0;
         sck_d   = 1'b0;
         bit_d   = 3'd7;
         cnt_d   = RELOAD;
         state_d = ST_SETUP;
      end
   end

   assign pop = load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         sr_q    <= '0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         sdi_q   <= 1'b0;
         dc_q    <= SSD_DC_CMD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         sdi_q   <= sdi_d;
         dc_q    <= dc_d;
      end
   end

   assign busy     = !empty || (state_q != ST_IDLE);
   assign spi_cs_n = cs_q;
   assign spi_sck  = sck_q;
   assign spi_sdi  = sdi_q;
   assign spi_dc   = dc_q;

endmodule
